// File: rtl/noc_ingress_fifo.sv
// NOC ingress stage: registers the {ctl,data} byte stream, finds the command
// byte on the falling edge of ctl, decodes it, and pushes the command word and
// its trailing payload bytes into a synchronous FIFO for the permutation engine.
module noc_ingress_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       noc_to_dev_ctl,
  input  logic [7:0]                 noc_to_dev_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 cmd_type,
  output logic [3:0]                 alen,
  output logic [7:0]                 dlen,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_WR   = 2'd1,
    CMD_RD   = 2'd2
  } cmd_e;

  localparam logic [2:0] OP_RD = 3'b001;
  localparam logic [2:0] OP_WR = 3'b010;

  logic [WIDTH-1:0] in_q, in_d;
  logic             ctl_q, ctl_d;
  logic [9:0]       cnt_q, cnt_d;
  cmd_e             cmd_type_q, cmd_type_d;
  logic [3:0]       alen_q, alen_d;
  logic [7:0]       dlen_q, dlen_d;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             ctl_fall;
  logic             wr_req;
  logic             do_wr;
  logic             do_rd;
  logic             empty_w;
  logic             full_w;
  logic [3:0]       alen_new;
  logic [7:0]       dlen_new;

  // in_q still holds the last ctl=1 byte when ctl drops, so it is the command
  assign ctl_fall = ctl_q & ~noc_to_dev_ctl;
  assign alen_new = 4'd1 << in_q[7:6];
  assign dlen_new = 8'd1 << in_q[5:3];

  assign empty_w = (count_q == CW'(0));
  assign full_w  = (count_q == CW'(DEPTH));

  // Input capture, command decode and payload counter
  always_comb begin
    in_d       = {noc_to_dev_ctl, noc_to_dev_data};
    ctl_d      = noc_to_dev_ctl;
    cnt_d      = cnt_q;
    cmd_type_d = cmd_type_q;
    alen_d     = alen_q;
    dlen_d     = dlen_q;
    if (ctl_fall) begin
      // Decode straight from in_q; the registered lengths are a cycle stale
      alen_d = alen_new;
      dlen_d = dlen_new;
      case (in_q[2:0])
        OP_WR: begin
          cmd_type_d = CMD_WR;
          cnt_d      = 10'(alen_new) + 10'(dlen_new) + 10'd2;
        end
        OP_RD: begin
          cmd_type_d = CMD_RD;
          cnt_d      = 10'(alen_new) + 10'd2;
        end
        default: begin
          cmd_type_d = cmd_type_q;
          cnt_d      = cnt_q;
        end
      endcase
    end else if (cnt_q != 10'd0) begin
      cnt_d = cnt_q - 10'd1;
    end
  end

  // FIFO pointer, occupancy, read data and overflow next-state
  always_comb begin
    wr_req     = ctl_fall | (cnt_q != 10'd0);
    do_wr      = wr_req & ~full_w;
    do_rd      = rd_en & ~empty_w;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q | (wr_req & full_w);
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem[rd_ptr_q];
    end
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q       <= '0;
      ctl_q      <= 1'b0;
      cnt_q      <= '0;
      cmd_type_q <= CMD_NONE;
      alen_q     <= '0;
      dlen_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_q       <= in_d;
      ctl_q      <= ctl_d;
      cnt_q      <= cnt_d;
      cmd_type_q <= cmd_type_d;
      alen_q     <= alen_d;
      dlen_q     <= dlen_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[wr_ptr_q] <= in_q;
    end
  end

  assign data_out = data_out_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign cmd_type = cmd_type_q;
  assign alen     = alen_q;
  assign dlen     = dlen_q;
  assign busy     = (cnt_q != 10'd0);

endmodule

// File: tb/tb_noc_ingress_fifo.sv
// Directed bench for noc_ingress_fifo: hand-computed expectations checked with
// immediate assertions after each clock step.
module tb_noc_ingress_fifo;

  localparam int DEPTH = 256;
  localparam int WIDTH = 9;

  logic                   clk;
  logic                   rst;
  logic                   noc_to_dev_ctl;
  logic [7:0]             noc_to_dev_data;
  logic                   rd_en;
  logic [WIDTH-1:0]       data_out;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [1:0]             cmd_type;
  logic [3:0]             alen;
  logic [7:0]             dlen;
  logic                   busy;

  int tests_run = 0;
  int tests_failed = 0;

  noc_ingress_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .noc_to_dev_ctl  (noc_to_dev_ctl),
    .noc_to_dev_data (noc_to_dev_data),
    .rd_en           (rd_en),
    .data_out        (data_out),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overflow        (overflow),
    .cmd_type        (cmd_type),
    .alen            (alen),
    .dlen            (dlen),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [7:0] d);
    noc_to_dev_ctl  = c;
    noc_to_dev_data = d;
    step();
  endtask

  // Write command 0x0A (alen=1, dlen=2) then pop all six words
  task automatic run_wr_cmd(input string pfx);
    logic [8:0] exp_words [6];
    logic [7:0] payload [5];
    exp_words = '{9'h10A, 9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    payload   = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drive(1'b1, 8'h0A);
    chk({pfx, "_busy_pre"}, busy, 0);
    drive(1'b0, 8'h11);
    chk({pfx, "_cmd_type"}, cmd_type, 1);
    chk({pfx, "_alen"}, alen, 1);
    chk({pfx, "_dlen"}, dlen, 2);
    chk({pfx, "_busy0"}, busy, 1);
    chk({pfx, "_count_cmd"}, count, 1);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, payload[k-1]);
      chk($sformatf("%s_busy%0d", pfx, k), busy, (k < 5) ? 1 : 0);
    end
    drive(1'b0, 8'h00);
    chk({pfx, "_count6"}, count, 6);
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("%s_pop%0d", pfx, k), data_out, exp_words[k]);
      chk($sformatf("%s_popcnt%0d", pfx, k), count, 5 - k);
    end
    rd_en = 1'b0;
    chk({pfx, "_empty_after"}, empty, 1);
  endtask

  initial begin
    rst = 1'b1;
    noc_to_dev_ctl = 1'b0;
    noc_to_dev_data = 8'h00;
    rd_en = 1'b0;
    step();
    step();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cmd_type", cmd_type, 0);
    chk("rst_alen", alen, 0);
    chk("rst_dlen", dlen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    step();

    run_wr_cmd("wr1");

    // Pop on empty FIFO: data_out holds last value, count stays 0
    rd_en = 1'b1;
    step();
    chk("empty_rd_data", data_out, 9'h055);
    chk("empty_rd_count", count, 0);
    rd_en = 1'b0;

    // Read command 0x41: alen=2, dlen=1, four trailing bytes
    drive(1'b1, 8'h41);
    drive(1'b0, 8'hA0);
    chk("rd_cmd_type", cmd_type, 2);
    chk("rd_alen", alen, 2);
    chk("rd_dlen", dlen, 1);
    chk("rd_busy", busy, 1);
    drive(1'b0, 8'hA1);
    drive(1'b0, 8'hA2);
    drive(1'b0, 8'hA3);
    chk("rd_busy_last", busy, 1);
    drive(1'b0, 8'h00);
    chk("rd_busy_done", busy, 0);
    chk("rd_count5", count, 5);
    rd_en = 1'b1;
    step();
    chk("rd_pop0", data_out, 9'h141);
    step();
    chk("rd_pop1", data_out, 9'h0A0);
    rd_en = 1'b0;
    chk("rd_count3", count, 3);

    // Unknown opcode 0x07 written as one word, concurrent with a pop at count=3
    drive(1'b1, 8'h07);
    rd_en = 1'b1;
    drive(1'b0, 8'h00);
    rd_en = 1'b0;
    chk("unk_concurrent_count", count, 3);
    chk("unk_concurrent_data", data_out, 9'h0A1);
    chk("unk_cmd_type", cmd_type, 2);
    chk("unk_busy", busy, 0);
    chk("unk_alen", alen, 1);
    chk("unk_dlen", dlen, 1);
    step();
    chk("unk_count_hold", count, 3);
    rd_en = 1'b1;
    step();
    chk("unk_pop0", data_out, 9'h0A2);
    step();
    chk("unk_pop1", data_out, 9'h0A3);
    step();
    chk("unk_pop2", data_out, 9'h107);
    rd_en = 1'b0;
    chk("unk_empty", empty, 1);

    // Maximal write 0xFA: alen=8, dlen=128, 139 words
    drive(1'b1, 8'hFA);
    drive(1'b0, 8'h00);
    chk("max_cmd_type", cmd_type, 1);
    chk("max_alen", alen, 8);
    chk("max_dlen", dlen, 128);
    for (int i = 1; i <= 138; i++) drive(1'b0, 8'(i));
    chk("max_count", count, 139);
    chk("max_busy", busy, 0);
    chk("max_overflow", overflow, 0);
    chk("max_full", full, 0);

    // Repeat without reading: fills at 256 and overflows
    drive(1'b1, 8'hFA);
    drive(1'b0, 8'h00);
    for (int i = 1; i <= 138; i++) drive(1'b0, 8'(i));
    chk("ovf_count", count, 256);
    chk("ovf_full", full, 1);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_empty", empty, 0);

    // Reset mid-command
    drive(1'b1, 8'h0A);
    drive(1'b0, 8'h11);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    drive(1'b0, 8'h22);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd", cmd_type, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_full", full, 0);
    rst = 1'b0;
    drive(1'b0, 8'h00);

    run_wr_cmd("wr2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noc_ingress_fifo.md
Name: noc_ingress_fifo

Overview:
- Ingress stage between the NOC byte link and a permutation engine.
- Registers the incoming 9-bit {ctl,data} stream and detects the falling edge of ctl, which marks the command byte.
- Decodes the command (read/write, address and data lengths) and writes the command word plus its trailing payload bytes into a synchronous FIFO.
- The downstream consumer drains the FIFO.

Parameters:
- DEPTH, 256, FIFO entries; power of two; ≥139 so one maximal write command fits.
- WIDTH, 9, FIFO word width: {ctl, data[7:0]}.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- noc_to_dev_ctl  in  1  NOC control flag; high marks a command byte
- noc_to_dev_data  in  8  NOC data byte
- rd_en  in  1  FIFO pop request
- data_out  out  9  FIFO read data, registered
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a write was attempted while full
- cmd_type  out  2  0=NONE, 1=WR, 2=RD; last decoded command
- alen  out  4  address length in bytes (1,2,4,8)
- dlen  out  8  data length in bytes (1..128)
- busy  out  1  payload counter nonzero

Behaviour:
- Reset (synchronous, rst=1 at clk edge) clears all of the following:
  - input register, ctl history, payload counter and FIFO pointers;
  - data_out=0, count=0, overflow=0, cmd_type=NONE, alen=0, dlen=0, busy=0;
  - resulting flags: empty=1, full=0.
  - Reset mid-command drops the command and all FIFO contents.
- Input register: every cycle in_q <= {noc_to_dev_ctl, noc_to_dev_data}.
- Edge detect: ctl_q <= noc_to_dev_ctl each cycle; ctl_fall = ctl_q & ~noc_to_dev_ctl (combinational).
  - In the ctl_fall cycle, in_q holds the last ctl=1 byte, which is the command.
- Command decode, on ctl_fall, using in_q[7:0]:
  - alen <= 1<<in_q[7:6]; dlen <= 1<<in_q[5:3].
  - Opcode in_q[2:0]=010 (write): cmd_type<=WR; cnt<=alen+dlen+2.
  - Opcode 001 (read): cmd_type<=RD; cnt<=alen+2.
  - Any other opcode: cmd_type and cnt unchanged.
  - Compute from in_q fields, not from the registered alen/dlen.
- Counter:
  - When no ctl_fall and cnt≠0, cnt decrements by 1 per cycle.
  - cnt is 10 bits wide.
  - A new ctl_fall while cnt≠0 reloads cnt (restart, no error).
- FIFO write:
  - wr = ctl_fall | (cnt≠0); write data = in_q.
  - Net effect: the command word (bit8=1) is written first, then cnt more words.
  - Write with full=1 is dropped, and overflow is set (sticky until rst).
- FIFO read:
  - Pop on rd_en & ~empty; data_out updates on the next clock edge and holds otherwise.
  - rd_en while empty is ignored (no pointer change, data_out held).
- Simultaneous read and write:
  - Not full, not empty: both occur; count unchanged.
  - Empty: write only.
  - Full: read occurs, write dropped (overflow set).
- Pointers wrap modulo DEPTH.
- Status outputs:
  - full = (count==DEPTH); empty = (count==0).
  - Both derived from registered count; no same-cycle bypass.
- busy = (cnt≠0).

Test Plan:
- Write cmd: drive ctl=1 data=0x0A for 1 cycle, then ctl=0 with bytes 0x11,0x22,0x33,0x44,0x55,0x66.
  - Expect cmd_type=WR, alen=1, dlen=2, busy for 5 cycles.
  - FIFO holds 6 words: 0x10A,0x011,0x022,0x033,0x044,0x055.
  - Pop them in order via rd_en, each data_out one cycle after its pop.
- Read cmd: ctl=1 data=0x41, then 0xA0,0xA1,0xA2,0xA3.
  - Expect cmd_type=RD, alen=2, dlen=1, cnt 4→0.
  - FIFO holds 0x141,0x0A0,0x0A1,0x0A2,0x0A3; count=5.
- Unknown opcode (ctl=1 data=0x07):
  - Exactly one word, 0x107, is written.
  - cmd_type unchanged; busy stays 0.
- Max write 0xFA (alen=8, dlen=128):
  - 139 words written; count=139; no overflow.
  - Repeat without reading: full asserts at 256, overflow=1, count stays 256.
- Empty/simultaneous: rd_en=1 on empty FIFO keeps data_out, count=0.
  - Concurrent pop and push at count=3 leaves count=3.
- Reset mid-command: assert rst during payload.
  - Next cycle: empty=1, busy=0, cmd_type=NONE.
  - Subsequent 0x0A command behaves as in the first scenario.
